// File: rtl/if_fetch_buf.sv
// Instruction fetch: owns the PC, reads the ROM one word per cycle, queues {pc, inst} for ID.
// Optional misaligned-redirect trap and HALT state when FETCH_ALIGN_CHECK_EN is defined.
module if_fetch_buf #(
    parameter int unsigned        ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter int unsigned        BUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [31:0]       rom_inst_i,
    input  logic              br_flag_i,
    input  logic [ADDR_W-1:0] br_addr_i,
    input  logic              id_ready_i,
    output logic              id_valid_o,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [31:0]       id_inst_o
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic              if_excp_o
`endif
);

    localparam int unsigned PtrW = $clog2(BUF_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;
`else
    typedef enum logic [1:0] {StIdle, StRun} state_e;
`endif

    state_e state_q, state_d;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] pc_mem   [BUF_DEPTH];
    logic [31:0]       inst_mem [BUF_DEPTH];

    logic              run, full, push, pop, redirect, valid;
    logic              misaligned;
    logic [ADDR_W-1:0] br_target;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned = |br_addr_i[1:0];
    assign br_target  = br_addr_i;
`else
    logic unused_br_lsb;
    assign unused_br_lsb = ^br_addr_i[1:0];
    assign misaligned    = 1'b0;
    assign br_target     = {br_addr_i[ADDR_W-1:2], 2'b00};
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: state_d = StRun;
            StRun: begin
                if (br_flag_i && misaligned) begin
`ifdef FETCH_ALIGN_CHECK_EN
                    state_d = StHalt;
`else
                    state_d = StRun;
`endif
                end
            end
`ifdef FETCH_ALIGN_CHECK_EN
            StHalt: begin
                if (br_flag_i && !misaligned) begin
                    state_d = StRun;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // Output / control decode
    always_comb begin
        run      = (state_q == StRun);
        full     = (cnt_q == CntW'(BUF_DEPTH));
        valid    = run && (cnt_q != '0) && !br_flag_i;
        pop      = valid && id_ready_i;
        push     = run && !br_flag_i && (!full || pop);
        redirect = br_flag_i && (state_q != StIdle);
    end

    assign rom_ce_o   = push;
    assign rom_addr_o = pc_q;
    assign id_valid_o = valid;
    assign id_pc_o    = valid ? pc_mem[rd_ptr_q] : '0;
    assign id_inst_o  = valid ? inst_mem[rd_ptr_q] : '0;
`ifdef FETCH_ALIGN_CHECK_EN
    // state_q is registered, so the flag rises the cycle after the offending redirect
    assign if_excp_o  = (state_q == StHalt);
`endif

    // PC and FIFO bookkeeping; a redirect flushes everything queued
    always_comb begin
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (redirect) begin
            pc_d     = br_target;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                pc_d     = pc_q + ADDR_W'(4);
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   cnt_d = cnt_q + CntW'(1);
                2'b01:   cnt_d = cnt_q - CntW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            pc_mem[wr_ptr_q]   <= pc_q;
            inst_mem[wr_ptr_q] <= rom_inst_i;
        end
    end

endmodule

// File: tb/tb_if_fetch_buf.sv
// Scoreboard bench for if_fetch_buf: stimulus queues expected {pc, inst}, a monitor checks pops.
// Build with FETCH_ALIGN_CHECK_EN defined to exercise the misaligned-redirect HALT path.
module tb_if_fetch_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        br_flag;
    logic [31:0] br_addr;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        if_excp;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t exp_q[$];

    always #5 clk = ~clk;

    // ROM[i] = 0x1000_0000 + i, word indexed
    assign rom_inst = 32'h1000_0000 + (rom_addr >> 2);

    if_fetch_buf #(
        .ADDR_W    (32),
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rom_ce_o   (rom_ce),
        .rom_addr_o (rom_addr),
        .rom_inst_i (rom_inst),
        .br_flag_i  (br_flag),
        .br_addr_i  (br_addr),
        .id_ready_i (id_ready),
        .id_valid_o (id_valid),
        .id_pc_o    (id_pc),
`ifdef FETCH_ALIGN_CHECK_EN
        .if_excp_o  (if_excp),
`endif
        .id_inst_o  (id_inst)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_pc(input logic [31:0] pc);
        entry_t e;
        e.pc   = pc;
        e.inst = 32'h1000_0000 + (pc >> 2);
        exp_q.push_back(e);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Returns right after the posedge that pops the last expected entry
    task automatic wait_drain(input string name, input int bound);
        bit done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            tick();
            if (exp_q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s drain: %0d entries left, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: a pop happens at the next posedge whenever valid & ready hold at negedge
    always @(negedge clk) begin
        if (!rst && id_valid && id_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got pc %08h, required no transfer", id_pc);
            end else begin
                entry_t e;
                e = exp_q.pop_front();
                chk("pop_pc", id_pc, e.pc);
                chk("pop_inst", id_inst, e.inst);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        br_flag  = 1'b0;
        br_addr  = 32'h0;
        id_ready = 1'b1;
        repeat (3) tick();

        // Reset state
        @(negedge clk);
        chk("rst_rom_ce", 32'(rom_ce), 32'h0);
        chk("rst_valid", 32'(id_valid), 32'h0);
        chk("rst_pc", id_pc, 32'h0);
        chk("rst_inst", id_inst, 32'h0);
        chk("rst_addr", rom_addr, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("rst_excp", 32'(if_excp), 32'h0);
`endif

        // 1: streaming from reset, one entry per cycle
        for (int i = 0; i < 8; i++) expect_pc(32'(i * 4));
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("s1_idle_ce", 32'(rom_ce), 32'h0);
        tick();
        @(negedge clk);
        chk("s1_first_ce", 32'(rom_ce), 32'h1);
        chk("s1_first_addr", rom_addr, 32'h0);
        chk("s1_first_valid", 32'(id_valid), 32'h0);
        tick();
        @(negedge clk);
        chk("s1_valid_lat", 32'(id_valid), 32'h1);
        wait_drain("s1", 20);

        // 2: back-pressure fills the FIFO, then drains in order
        rst      = 1'b1;
        id_ready = 1'b0;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        chk("s2_full_ce", 32'(rom_ce), 32'h0);
        chk("s2_full_addr", rom_addr, 32'h10);
        chk("s2_head_pc", id_pc, 32'h0);
        for (int i = 0; i < 6; i++) expect_pc(32'(i * 4));
        tick();
        id_ready = 1'b1;
        wait_drain("s2", 20);

        // 5: reset dominates a redirect with the FIFO full
        rst     = 1'b1;
        br_flag = 1'b1;
        br_addr = 32'h300;
        @(negedge clk);
        chk("s5_br_valid", 32'(id_valid), 32'h0);
        tick();
        rst      = 1'b0;
        br_flag  = 1'b0;
        id_ready = 1'b0;
        @(negedge clk);
        chk("s5_rst_ce", 32'(rom_ce), 32'h0);
        chk("s5_rst_valid", 32'(id_valid), 32'h0);
        chk("s5_rst_addr", rom_addr, 32'h0);

        // 3: redirect with three entries queued flushes them
        repeat (3) tick();
        @(negedge clk);
        chk("s3_pre_addr", rom_addr, 32'h8);
        chk("s3_pre_pc", id_pc, 32'h0);
        tick();
        br_flag  = 1'b1;
        br_addr  = 32'h100;
        id_ready = 1'b1;
        for (int i = 0; i < 3; i++) expect_pc(32'h100 + 32'(i * 4));
        @(negedge clk);
        chk("s3_br_valid", 32'(id_valid), 32'h0);
        chk("s3_br_ce", 32'(rom_ce), 32'h0);
        tick();
        br_flag = 1'b0;
        @(negedge clk);
        chk("s3_tgt_addr", rom_addr, 32'h100);
        chk("s3_tgt_valid", 32'(id_valid), 32'h0);
        tick();
        @(negedge clk);
        chk("s3_tgt_vis", 32'(id_valid), 32'h1);
        wait_drain("s3", 20);

        // 4: PC wraps at the top of the address space
        br_flag = 1'b1;
        br_addr = 32'hFFFF_FFFC;
        expect_pc(32'hFFFF_FFFC);
        expect_pc(32'h0000_0000);
        expect_pc(32'h0000_0004);
        tick();
        br_flag = 1'b0;
        wait_drain("s4", 20);

        // 6: misaligned redirect
        br_flag = 1'b1;
        br_addr = 32'h102;
`ifdef FETCH_ALIGN_CHECK_EN
        @(negedge clk);
        chk("s6_excp_pre", 32'(if_excp), 32'h0);
        tick();
        br_flag = 1'b0;
        @(negedge clk);
        chk("s6_excp", 32'(if_excp), 32'h1);
        chk("s6_halt_ce", 32'(rom_ce), 32'h0);
        chk("s6_halt_valid", 32'(id_valid), 32'h0);
        repeat (3) tick();
        @(negedge clk);
        chk("s6_excp_hold", 32'(if_excp), 32'h1);
        chk("s6_hold_ce", 32'(rom_ce), 32'h0);
        tick();
        br_flag = 1'b1;
        br_addr = 32'h200;
        for (int i = 0; i < 3; i++) expect_pc(32'h200 + 32'(i * 4));
        tick();
        br_flag = 1'b0;
        @(negedge clk);
        chk("s6_excp_clr", 32'(if_excp), 32'h0);
        chk("s6_resume_addr", rom_addr, 32'h200);
        wait_drain("s6", 20);
`else
        for (int i = 0; i < 3; i++) expect_pc(32'h100 + 32'(i * 4));
        tick();
        br_flag = 1'b0;
        @(negedge clk);
        chk("s6_trunc_addr", rom_addr, 32'h100);
        wait_drain("s6", 20);
`endif

        id_ready = 1'b0;
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
